div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle 32-bit divider sequencer for the EX stage, serving `div` and `divu`. It accepts a start request from EX and runs a 32-iteration restoring shift-subtract loop. It returns `{remainder, quotient}` with a ready flag, which EX writes to HI/LO. EX raises `stallreq_from_ex` while a divide is started and `ready_o` is low. The flush path can annul an in-flight divide.

## Interface
- `WIDTH`, 32: operand width. Fixed; the design is only verified at 32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  divide request. Held high by EX until it consumes the result.
- `annul_i`  in  1  cancel the request or in-flight divide (pipeline flush).
- `signed_div_i`  in  1  1 = `div` (two's complement), 0 = `divu`.
- `opdata1_i`  in  32  dividend. Sampled only on the FREE→ON/BYZERO transition.
- `opdata2_i`  in  32  divisor. Sampled with `opdata1_i`.
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`; maps to `{HI, LO}`.
- `ready_o`  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. All outputs and state are registered.
- Reset:
  - state = FREE
  - `result_o` = 0, `ready_o` = 0
  - iteration counter, remainder, quotient, divisor and sign flags = 0.
- FREE:
  - `start_i && !annul_i && opdata2_i == 0` → BYZERO.
  - `start_i && !annul_i` → ON. On this transition:
    - counter = 0
    - quotient register = |opdata1_i|
    - remainder register = 0
    - divisor register = |opdata2_i|
    - latch `neg_q = signed && (op1[31] ^ op2[31])` and `neg_r = signed && op1[31]`.
  - Absolute value is taken only if `signed_div_i` is set and bit 31 is set. It is computed as `~x + 1` in 32 bits; 0x80000000 yields unsigned 2^31.
  - Otherwise FREE is held and `ready_o` = 0.
- BYZERO:
  - Unconditionally → END with `result_o` = 0 and `ready_o` = 1.
  - If `annul_i` is high → FREE instead, and `ready_o` stays 0.
- ON, counter < 32, one iteration per cycle:
  - `t = {rem[31:0], quot[31]} - {1'b0, divisor}`, computed 33 bits wide.
  - If `t[32] == 0`: `rem = t[31:0]` and `quot = {quot[30:0], 1}`.
  - Else: `rem = {rem[30:0], quot[31]}` and `quot = {quot[30:0], 0}`.
  - counter += 1.
- ON, counter == 32:
  - quotient = `neg_q ? -quot : quot`; remainder = `neg_r ? -rem : rem`. Both are 32-bit wrap.
  - Write `result_o` = `{remainder, quotient}`, set `ready_o` = 1, → END.
- `annul_i` in ON (any counter value): → FREE next cycle, `ready_o` stays 0, `result_o` = 0.
- END: `result_o` and `ready_o` = 1 are held while `start_i` is high. When `start_i` goes low: → FREE, with `ready_o` = 0 and `result_o` = 0 next cycle.
- `annul_i` in END → FREE; same as `start_i` low.
- Arithmetic conventions:
  - Truncating division; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. This is the wrap result; no exception is raised.
- `rst` overrides all states, mid-operation included.

## Timing
- Cycle 0: `start_i` is sampled at edge E1, and the state moves to ON or BYZERO.
- Normal divide:
  - Iterations occur at edges E2..E33.
  - Correction and `ready_o` occur at E34.
  - `ready_o` is first high in the cycle after E34, i.e. 34 cycles after the sampling edge.
- Divide by zero: `ready_o` is high after E2.
- After `start_i` deasserts: `ready_o` drops one cycle later. A new start is accepted only from FREE, so there are at least 2 cycles between consecutive results.
- `opdata*_i` changes after E1 have no effect on the in-flight result.

## Test plan
- divu 100 / 7 → after 34 cycles `ready_o` = 1 and `result_o` = {0x00000002, 0x0000000E}. `ready_o` must be 0 on cycles 1..33.
- div −7 / 2 (0xFFFFFFF9, 0x00000002) → {0xFFFFFFFF, 0xFFFFFFFD}. Also check 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero, with div and divu, opdata1 = 0x1234 → `ready_o` after 2 cycles and `result_o` = 0. Then drop `start_i` → `ready_o` = 0 next cycle.
- div 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. divu with the same operands → {0x80000000, 0x00000000}.
- Annul and reset mid-operation:
  - Assert `annul_i` at counter = 10 → FREE, no `ready_o` pulse. An immediately following divu 0xFFFFFFFF / 1 completes correctly.
  - Assert `rst` at counter = 20 → all outputs 0 next cycle.
- Hold `start_i` high for 5 cycles in END while toggling `opdata*_i` → `result_o` stays stable. Drop `start_i` → FREE, and a new start is accepted on the following edge.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake bundle between EX and the sequential divider.
// EX drives the request side; the divider returns {HI, LO} with a ready flag.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per cycle on
// operand magnitudes, sign correction on the last step, result held until EX drops start.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);
  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  typedef struct packed {
    logic             sgn;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
  } req_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quot, quot_nxt;
  logic [WIDTH-1:0]   dvsr, dvsr_nxt;
  logic               neg_quot, neg_quot_nxt;
  logic               neg_rem, neg_rem_nxt;
  logic [2*WIDTH-1:0] result, result_nxt;
  logic               ready, ready_nxt;
  logic [WIDTH:0]     step;
  req_t               req;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // 0x80000000 maps onto itself, which reads correctly as unsigned 2^31.
  function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
    return (sgn && x[WIDTH-1]) ? neg(x) : x;
  endfunction

  assign req  = '{sgn: bus.signed_div_i, op1: bus.opdata1_i, op2: bus.opdata2_i};
  // Trial subtract of the divisor from the next partial remainder; bit WIDTH is the borrow.
  assign step = {rem, quot[WIDTH-1]} - {1'b0, dvsr};

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    quot_nxt     = quot;
    dvsr_nxt     = dvsr;
    neg_quot_nxt = neg_quot;
    neg_rem_nxt  = neg_rem;
    result_nxt   = result;
    ready_nxt    = ready;

    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (req.op2 == '0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt    = ON;
            cnt_nxt      = '0;
            rem_nxt      = '0;
            quot_nxt     = mag(req.sgn, req.op1);
            dvsr_nxt     = mag(req.sgn, req.op2);
            neg_quot_nxt = req.sgn & (req.op1[WIDTH-1] ^ req.op2[WIDTH-1]);
            neg_rem_nxt  = req.sgn & req.op1[WIDTH-1];
          end
        end
      end

      BYZERO: begin
        result_nxt = '0;
        if (bus.annul_i) begin
          state_nxt = FREE;
          ready_nxt = 1'b0;
        end else begin
          state_nxt = END;
          ready_nxt = 1'b1;
        end
      end

      ON: begin
        if (bus.annul_i) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt != LAST) begin
          if (!step[WIDTH]) begin
            rem_nxt  = step[WIDTH-1:0];
            quot_nxt = {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem_nxt  = {rem[WIDTH-2:0], quot[WIDTH-1]};
            quot_nxt = {quot[WIDTH-2:0], 1'b0};
          end
          cnt_nxt = cnt + 1'b1;
        end else begin
          // Truncating division: quotient sign from operand signs, remainder follows dividend.
          result_nxt = {neg_rem  ? neg(rem)  : rem,
                        neg_quot ? neg(quot) : quot};
          ready_nxt  = 1'b1;
          state_nxt  = END;
        end
      end

      END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end

      default: begin
        state_nxt  = FREE;
        ready_nxt  = 1'b0;
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      quot     <= quot_nxt;
      dvsr     <= dvsr_nxt;
      neg_quot <= neg_quot_nxt;
      neg_rem  <= neg_rem_nxt;
      result   <= result_nxt;
      ready    <= ready_nxt;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results queued at launch, popped on ready.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) bus();
  div_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Launch, wait for ready, compare, optionally hold in END while toggling operands, then release.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold);
    logic [63:0] e;
    int lat, exp_lat;
    sb.push_back(exp);
    exp_lat = (b == 32'd0) ? 2 : 34;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.ready_o && lat < 60);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    chk({tag, "_result"}, bus.result_o, e);
    repeat (hold) begin
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~bus.signed_div_i;
      tick();
      chk({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
      chk({tag, "_hold_result"}, bus.result_o, e);
    end
    bus.start_i = 1'b0;
    tick();
    chk({tag, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_drop_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int pulses;
    logic s;
    logic [31:0] a, b;

    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    tick();
    tick();
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 0);
    run_div("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
    run_div("div_7_m2",   1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0);
    run_div("div_by0",    1'b1, 32'h00001234, 32'h0, 64'd0, 0);
    run_div("divu_by0",   1'b0, 32'h00001234, 32'h0, 64'd0, 0);
    run_div("div_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 0);
    run_div("divu_ovf",   1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 0);

    // Annul at counter 10, then an immediate back-to-back divide.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    pulses = 0;
    repeat (11) begin
      tick();
      if (bus.ready_o) pulses++;
    end
    bus.annul_i = 1'b1;
    tick();
    if (bus.ready_o) pulses++;
    chk("annul_no_pulse", 64'(pulses), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    run_div("post_annul", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h00000000, 32'hFFFFFFFF}, 0);

    // Reset at counter 20.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'h11;
    bus.start_i      = 1'b1;
    repeat (21) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Hold in END with operands toggling, then a new start right after release.
    run_div("hold_end", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 5);
    run_div("after_hold", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 0);

    repeat (8) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_div("rand", s, a, b, model(s, a, b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
